// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, FSM state type and per-iteration approximation level
package div_pkg;

   localparam int DW = 8;
   localparam int XW = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Trailing quotient bits get progressively more approximate LSB cells.
   function automatic logic [3:0] approx_level(input int i, input int approx_rows);
      if (i < approx_rows) begin
         return 4'(approx_rows - i);
      end
      return 4'd0;
   endfunction

endpackage

// File: rtl/div_row.sv
// rtl/div_row.sv - one subtract/restore row; the l lowest cells use approximate borrow/restore logic
module div_row
   import div_pkg::*;
(
   input  logic [DW:0]   x,
   input  logic [DW-1:0] y,
   input  logic          bin,
   input  logic [3:0]    l,
   output logic          qs,
   output logic [DW-1:0] r
);

   logic [DW:0] b;

   always_comb begin
      b    = '0;
      b[0] = bin;
      for (int j = 0; j < DW; j++) begin
         if (j < int'(l)) begin
            b[j+1] = b[j] & (y[j] | ~x[j]);
         end else begin
            b[j+1] = (~x[j] & b[j]) | (~x[j] & y[j]) | (y[j] & b[j]);
         end
      end
   end

   assign qs = ~b[DW] | x[DW];

   always_comb begin
      r = '0;
      for (int j = 0; j < DW; j++) begin
         if (j < int'(l)) begin
            r[j] = x[j] | (qs & (y[j] ^ b[j]));
         end else begin
            r[j] = qs ? (x[j] ^ y[j] ^ b[j]) : x[j];
         end
      end
   end

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - 16/8 sequential restoring divider controller, one quotient bit per cycle
// DIV_SEQ_STATUS_EN adds registered divide-by-zero (out_dz) and overflow (out_ovf) flags.
module div_seq_ctrl
   import div_pkg::*;
#(
   parameter int APPROX_ROWS = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] in_dividend,
   input  logic [DW-1:0] in_divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_quot,
`ifdef DIV_SEQ_STATUS_EN
   output logic          out_dz,
   output logic          out_ovf,
`endif
   output logic [DW-1:0] out_rem
);

   state_t        state;
   logic [XW-1:0] dividend;
   logic [DW-1:0] divisor;
   logic [DW-1:0] quot;
   logic [DW:0]   p;
   logic [2:0]    i;
   logic [3:0]    lvl;
   logic          row_qs;
   logic [DW-1:0] row_r;

   assign lvl = approx_level(int'(i), APPROX_ROWS);

   div_row u_row (
      .x   (p),
      .y   (divisor),
      .bin (1'b0),
      .l   (lvl),
      .qs  (row_qs),
      .r   (row_r)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_quot  <= '0;
         out_rem   <= '0;
         dividend  <= '0;
         divisor   <= '0;
         quot      <= '0;
         p         <= '0;
         i         <= '0;
`ifdef DIV_SEQ_STATUS_EN
         out_dz    <= 1'b0;
         out_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  dividend <= in_dividend;
                  divisor  <= in_divisor;
                  p        <= in_dividend[XW-1:DW-1];
                  i        <= 3'd7;
                  in_ready <= 1'b0;
                  state    <= RUN;
`ifdef DIV_SEQ_STATUS_EN
                  out_dz   <= (in_divisor == '0);
                  out_ovf  <= (in_divisor != '0) && (in_dividend[XW-1:DW] >= in_divisor);
`endif
               end
            end
            RUN: begin
               quot[i] <= row_qs;
               if (i != 3'd0) begin
                  p <= {row_r, dividend[4'(i) - 4'd1]};
                  i <= i - 3'd1;
               end else begin
                  // Publish the whole result at once so outputs never show a partial quotient.
                  out_quot  <= {quot[DW-1:1], row_qs};
                  out_rem   <= row_r;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - exact and approximate divider instances against a reference model
module tb_div_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] in_dividend = '0;
   logic [7:0]  in_divisor = '0;

   logic        a_in_ready, a_out_valid, e_in_ready, e_out_valid;
   logic [7:0]  a_q, a_r, e_q, e_r;
`ifdef DIV_SEQ_STATUS_EN
   logic        a_dz, a_ovf, e_dz, e_ovf;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_seq_ctrl #(.APPROX_ROWS(3)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (a_in_ready),
      .in_dividend (in_dividend),
      .in_divisor  (in_divisor),
      .out_valid   (a_out_valid),
      .out_ready   (out_ready),
      .out_quot    (a_q),
`ifdef DIV_SEQ_STATUS_EN
      .out_dz      (a_dz),
      .out_ovf     (a_ovf),
`endif
      .out_rem     (a_r)
   );

   div_seq_ctrl #(.APPROX_ROWS(0)) u_exact (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (e_in_ready),
      .in_dividend (in_dividend),
      .in_divisor  (in_divisor),
      .out_valid   (e_out_valid),
      .out_ready   (out_ready),
      .out_quot    (e_q),
`ifdef DIV_SEQ_STATUS_EN
      .out_dz      (e_dz),
      .out_ovf     (e_ovf),
`endif
      .out_rem     (e_r)
   );

   typedef struct {
      logic [15:0] x;
      logic [7:0]  y;
      logic [7:0]  q;
      logic [7:0]  r;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Chained rows: exact rows as plain compare/subtract, approximate rows from the cell equations.
   function automatic void ref_div(input logic [15:0] x, input logic [7:0] y, input int ar,
                                   output logic [7:0] q, output logic [7:0] r);
      logic [8:0] p;
      logic [8:0] b;
      logic [7:0] rr;
      logic       qs;
      int         l;
      p = x[15:7];
      q = '0;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         l = (i < ar) ? ar - i : 0;
         if (l == 0) begin
            qs = (p >= {1'b0, y});
            rr = qs ? 8'(p - {1'b0, y}) : p[7:0];
         end else begin
            b[0] = 1'b0;
            for (int j = 0; j < 8; j++) begin
               if (j < l) b[j+1] = b[j] & (y[j] | ~p[j]);
               else       b[j+1] = (~p[j] & b[j]) | (~p[j] & y[j]) | (y[j] & b[j]);
            end
            qs = ~b[8] | p[8];
            for (int j = 0; j < 8; j++) begin
               if (j < l) rr[j] = p[j] | (qs & (y[j] ^ b[j]));
               else       rr[j] = qs ? (p[j] ^ y[j] ^ b[j]) : p[j];
            end
         end
         q[i] = qs;
         if (i > 0) p = {rr, x[i-1]};
         else       r = rr;
      end
   endfunction

   function automatic void ref_exact(input logic [15:0] x, input logic [7:0] y,
                                     output logic [7:0] q, output logic [7:0] r);
      if (y != 0 && x[15:8] < y) begin
         q = 8'(x / {8'd0, y});
         r = 8'(x % {8'd0, y});
      end else begin
         ref_div(x, y, 0, q, r);
      end
   endfunction

   task automatic wait_valid(output int edges);
      edges = 0;
      while (!a_out_valid && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk("out_valid_seen", a_out_valid, 1);
   endtask

   task automatic check_result(input logic [15:0] x, input logic [7:0] y,
                               input logic [7:0] eq, input logic [7:0] er);
      logic [7:0] aq, ar_;
      ref_div(x, y, 3, aq, ar_);
      chk("exact_valid", e_out_valid, 1);
      chk("exact_quot", e_q, eq);
      chk("exact_rem", e_r, er);
      chk("approx_quot", a_q, aq);
      chk("approx_rem", a_r, ar_);
`ifdef DIV_SEQ_STATUS_EN
      chk("dz", a_dz, (y == 0));
      chk("ovf", a_ovf, (y != 0) && (x[15:8] >= y));
      chk("exact_dz", e_dz, (y == 0));
`endif
   endtask

   task automatic do_div(input logic [15:0] x, input logic [7:0] y,
                         input logic [7:0] eq, input logic [7:0] er);
      int edges;
      chk("in_ready_idle", a_in_ready, 1);
      in_dividend = x;
      in_divisor  = y;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(edges);
      chk("latency", edges, 8);
      check_result(x, y, eq, er);
      @(posedge clk);
      #1;
      chk("valid_drop", a_out_valid, 0);
      chk("in_ready_back", a_in_ready, 1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[8];
      int          edges;
      logic [15:0] x;
      logic [7:0]  y, eq, er;

      vecs[0] = '{16'd1000,  8'd7,    8'd142,  8'd6};
      vecs[1] = '{16'd0,     8'd5,    8'd0,    8'd0};
      vecs[2] = '{16'h1234,  8'd0,    8'hFF,   8'h34};
      vecs[3] = '{16'h0900,  8'd8,    8'hFF,   8'd8};
      vecs[4] = '{16'h7FFF,  8'h80,   8'd255,  8'd127};
      vecs[5] = '{16'd255,   8'd1,    8'd255,  8'd0};
      vecs[6] = '{16'd100,   8'd200,  8'd0,    8'd100};
      vecs[7] = '{16'h00FF,  8'h10,   8'd15,   8'd15};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_quot", a_q, 0);
      chk("rst_rem", a_r, 0);
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_exact_valid", e_out_valid, 0);
      chk("rst_exact_quot", e_q, 0);
`ifdef DIV_SEQ_STATUS_EN
      chk("rst_dz", a_dz, 0);
      chk("rst_ovf", a_ovf, 0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 8; k++) begin
         do_div(vecs[k].x, vecs[k].y, vecs[k].q, vecs[k].r);
      end

      // Backpressure with a competing request held during RUN and DONE.
      in_dividend = 16'd1000;
      in_divisor  = 8'd7;
      in_valid    = 1'b1;
      out_ready   = 1'b0;
      @(posedge clk);
      #1;
      in_dividend = 16'h4321;
      in_divisor  = 8'h99;
      chk("bp_run_in_ready", a_in_ready, 0);
      wait_valid(edges);
      chk("bp_latency", edges, 8);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_valid", a_out_valid, 1);
         chk("bp_hold_quot", e_q, 142);
         chk("bp_hold_rem", e_r, 6);
         chk("bp_hold_in_ready", a_in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", a_out_valid, 0);
      chk("bp_release_in_ready", a_in_ready, 1);
      chk("bp_release_quot_hold", e_q, 142);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_second_accept", a_in_ready, 0);
      wait_valid(edges);
      chk("bp_second_latency", edges, 8);
      ref_exact(16'h4321, 8'h99, eq, er);
      check_result(16'h4321, 8'h99, eq, er);
      @(posedge clk);
      #1;

      // Reset while iteration i=3 is pending.
      in_dividend = 16'd500;
      in_divisor  = 8'd3;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_valid", a_out_valid, 0);
      chk("midrst_quot", a_q, 0);
      chk("midrst_rem", a_r, 0);
      chk("midrst_exact_quot", e_q, 0);
      chk("midrst_in_ready", a_in_ready, 1);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         chk("midrst_no_stale", a_out_valid | e_out_valid, 0);
      end
      do_div(16'd1000, 8'd7, 8'd142, 8'd6);

      for (int n = 0; n < 3000; n++) begin
         y = 8'($urandom_range(0, 255));
         x = 16'($urandom);
         if ((n % 2) == 1 && y != 0) x[15:8] = 8'($urandom_range(0, int'(y) - 1));
         ref_exact(x, y, eq, er);
         do_div(x, y, eq, er);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
